user_led_driver: RTL



---
 rtl/user_led_pkg.sv | 24 ++
 rtl/user_led_channel.sv | 55 +++++
 rtl/user_led_driver.sv | 82 ++++++++
 3 files changed

// File: rtl/user_led_pkg.sv
// rtl/user_led_pkg.sv - shared types and constants for the user LED driver
package user_led_pkg;

    localparam int LED_NUM = 4;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_PWM   = 2'd2,
        LED_BLINK = 2'd3
    } led_mode_e;

    typedef struct packed {
        led_mode_e   mode;
        logic [7:0]  duty;
        logic [7:0]  period;
    } led_cfg_t;

    // A programmed half-period of 0 ms behaves as 1 ms
    function automatic logic [7:0] eff_period(input logic [7:0] period);
        return (period == 8'd0) ? 8'd1 : period;
    endfunction

endpackage

// File: rtl/user_led_channel.sv
// rtl/user_led_channel.sv - one LED: config, blink counter/phase and lit decode
module user_led_channel
    import user_led_pkg::*;
(
    input  logic        iSysClk,
    input  logic        iSysRst,
    input  logic        iWe,
    input  led_cfg_t    iCfg,
    input  logic        iTick,
    input  logic [7:0]  iPwmCnt,
    output logic        oLit
);

    led_cfg_t    r_cfg;
    logic [7:0]  r_blink_cnt;
    logic        r_phase;
    logic [7:0]  w_pe_last;
    logic        w_pwm_on;

    assign w_pe_last = eff_period(r_cfg.period) - 8'd1;
    assign w_pwm_on  = (iPwmCnt < r_cfg.duty);

    // Config load restarts the blink lit; otherwise blink advances once per ms tick
    always_ff @(posedge iSysClk) begin
        if (iSysRst) begin
            r_cfg       <= '{mode: LED_OFF, duty: 8'd0, period: 8'd0};
            r_blink_cnt <= 8'd0;
            r_phase     <= 1'b0;
        end else if (iWe) begin
            r_cfg       <= iCfg;
            r_blink_cnt <= 8'd0;
            r_phase     <= 1'b1;
        end else if (iTick && (r_cfg.mode == LED_BLINK)) begin
            if (r_blink_cnt == w_pe_last) begin
                r_blink_cnt <= 8'd0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 8'd1;
            end
        end
    end

    // Decode the lit state from mode, shared PWM count and blink phase
    always_comb begin
        oLit = 1'b0;
        case (r_cfg.mode)
            LED_OFF:   oLit = 1'b0;
            LED_ON:    oLit = 1'b1;
            LED_PWM:   oLit = w_pwm_on;
            LED_BLINK: oLit = r_phase & w_pwm_on;
            default:   oLit = 1'b0;
        endcase
    end

endmodule

// File: rtl/user_led_driver.sv
// rtl/user_led_driver.sv - four user LEDs with on/off/PWM/blink modes
module user_led_driver
    import user_led_pkg::*;
#(
    parameter int pSysClk    = 125000,
    parameter int pPwmDiv    = 16,
    parameter bit pActiveLow = 1'b0
) (
    input  logic                iSysClk,
    input  logic                iSysRst,
    input  logic                iLedWe,
    input  logic [1:0]          iLedSel,
    input  logic [1:0]          iLedMode,
    input  logic [7:0]          iLedDuty,
    input  logic [7:0]          iLedPeriod,
    output logic [LED_NUM-1:0]  oUserLed
);

    localparam int TW = (pSysClk > 1) ? $clog2(pSysClk) : 1;
    localparam int PW = (pPwmDiv > 1) ? $clog2(pPwmDiv) : 1;

    logic [TW-1:0]       r_tick_cnt;
    logic [PW-1:0]       r_pre_cnt;
    logic [7:0]          r_pwm_cnt;
    logic [LED_NUM-1:0]  r_led;
    logic                w_tick;
    logic                w_pwm_step;
    led_cfg_t            w_cfg;
    logic [LED_NUM-1:0]  w_we;
    logic [LED_NUM-1:0]  w_lit;

    assign w_tick     = (r_tick_cnt == TW'(pSysClk - 1));
    assign w_pwm_step = (r_pre_cnt == PW'(pPwmDiv - 1));
    assign w_cfg      = '{mode: led_mode_e'(iLedMode), duty: iLedDuty, period: iLedPeriod};
    assign oUserLed   = r_led;

    // Free-running millisecond tick counter
    always_ff @(posedge iSysClk) begin
        if (iSysRst) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
        end
    end

    // PWM prescaler and shared 8-bit PWM counter (wraps 255 -> 0)
    always_ff @(posedge iSysClk) begin
        if (iSysRst) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= 8'd0;
        end else begin
            r_pre_cnt <= w_pwm_step ? '0 : r_pre_cnt + PW'(1);
            if (w_pwm_step) begin
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
            end
        end
    end

    for (genvar g = 0; g < LED_NUM; g++) begin : g_ch
        assign w_we[g] = iLedWe && (iLedSel == 2'(g));

        user_led_channel u_ch (
            .iSysClk (iSysClk),
            .iSysRst (iSysRst),
            .iWe     (w_we[g]),
            .iCfg    (w_cfg),
            .iTick   (w_tick),
            .iPwmCnt (r_pwm_cnt),
            .oLit    (w_lit[g])
        );
    end

    // Registered LED drive with board polarity applied
    always_ff @(posedge iSysClk) begin
        if (iSysRst) begin
            r_led <= {LED_NUM{pActiveLow}};
        end else begin
            r_led <= w_lit ^ {LED_NUM{pActiveLow}};
        end
    end

endmodule
